// File: rtl/siteswap_scheduler.sv
// Siteswap beat scheduler: picks the thrown ball and its height on every beat, tracks in-flight balls.
// Latency: every beat result is registered and appears exactly one cycle after new_beat.
// Backpressure: none; one beat per new_beat pulse, downstream must accept each pulse as issued.
//
// Ports:
//   clk_in, rst_n_in                 clock, asynchronous active-low reset
//   new_beat                         one-cycle beat pulse
//   pattern_in                       MAX_LEN 3-bit throw heights, entry 0 in bits [2:0]
//   pattern_length, num_balls_in     active entries (1..7) and ball count, latched at load
//   pattern_valid_in                 level; a rising edge loads the pattern, a low level stops the run
//   throw_valid_out                  one-cycle pulse: a throw occurred
//   throw_ball_out, throw_height_out ball id / height of the last throw (held until next throw)
//   empty_beat_out                   one-cycle pulse: height-0 beat with an empty hand
//   pattern_idx_out                  pattern index of the last processed beat
//   running_out                      high while in RUN
//   error_out                        sticky collision / empty-hand error
//   throw_hand_out                   (only with SISWAP_HAND_EN) hand of the throw, 0=right 1=left
module siteswap_scheduler #(
    parameter int MAX_LEN = 7,
    parameter int SLOTS   = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 new_beat,
    input  logic [3*MAX_LEN-1:0] pattern_in,
    input  logic [2:0]           pattern_length,
    input  logic [2:0]           num_balls_in,
    input  logic                 pattern_valid_in,
    output logic                 throw_valid_out,
    output logic [2:0]           throw_ball_out,
    output logic [2:0]           throw_height_out,
    output logic                 empty_beat_out,
    output logic [2:0]           pattern_idx_out,
    output logic                 running_out,
    output logic                 error_out
`ifdef SISWAP_HAND_EN
    ,
    output logic                 throw_hand_out
`endif
);

    localparam int PW = $clog2(SLOTS);

    typedef enum logic {IDLE, RUN} state_t;

    state_t state, state_nxt;

    logic [2:0]    pat_q [MAX_LEN];
    logic [2:0]    len_q;
    logic [2:0]    nb_q;
    logic [SLOTS-1:0] occ;
    logic [2:0]    qball [SLOTS];
    logic [PW-1:0] head;
    logic [2:0]    idx;
    logic [2:0]    fresh_cnt;
    logic          prev_valid;
`ifdef SISWAP_HAND_EN
    logic          beat_par;
`endif

    // Control decisions
    logic          rise;
    logic          load;
    logic          load_bad;
    logic          drop;
    logic          beat_go;

    // Beat datapath
    logic [2:0]    h;
    logic          slot_occ;
    logic          hand_vld;
    logic [2:0]    hand_ball;
    logic          fresh_take;
    logic [PW-1:0] tgt;

    assign rise        = pattern_valid_in & ~prev_valid;
    assign running_out = (state == RUN);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_bad  = 1'b0;
        drop      = 1'b0;
        beat_go   = 1'b0;
        case (state)
            IDLE: begin
                // A beat arriving together with the load edge is deliberately dropped.
                if (rise) begin
                    if (num_balls_in == 3'd0 || pattern_length == 3'd0) begin
                        load_bad = 1'b1;
                    end else begin
                        load      = 1'b1;
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (!pattern_valid_in) begin
                    drop      = 1'b1;
                    state_nxt = IDLE;
                end else if (new_beat) begin
                    beat_go = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Hand selection: a landing ball has priority; otherwise a fresh ball is introduced
    // only for a real throw (h != 0) while unused balls remain.
    always_comb begin
        h          = pat_q[idx];
        slot_occ   = occ[head];
        hand_vld   = 1'b0;
        hand_ball  = 3'd0;
        fresh_take = 1'b0;
        if (slot_occ) begin
            hand_vld  = 1'b1;
            hand_ball = qball[head];
        end else if (fresh_cnt < nb_q && h != 3'd0) begin
            hand_vld   = 1'b1;
            hand_ball  = fresh_cnt;
            fresh_take = 1'b1;
        end
        // Pointer add wraps mod SLOTS; heights < SLOTS can never land back on head.
        tgt = head + PW'(h);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < MAX_LEN; i++) pat_q[i] <= 3'd0;
            for (int i = 0; i < SLOTS; i++) qball[i] <= 3'd0;
            len_q            <= 3'd0;
            nb_q             <= 3'd0;
            occ              <= '0;
            head             <= '0;
            idx              <= 3'd0;
            fresh_cnt        <= 3'd0;
            prev_valid       <= 1'b0;
            throw_valid_out  <= 1'b0;
            throw_ball_out   <= 3'd0;
            throw_height_out <= 3'd0;
            empty_beat_out   <= 1'b0;
            pattern_idx_out  <= 3'd0;
            error_out        <= 1'b0;
`ifdef SISWAP_HAND_EN
            beat_par         <= 1'b0;
            throw_hand_out   <= 1'b0;
`endif
        end else begin
            prev_valid      <= pattern_valid_in;
            throw_valid_out <= 1'b0;
            empty_beat_out  <= 1'b0;

            if (load_bad) begin
                error_out <= 1'b1;
            end

            if (load) begin
                for (int i = 0; i < MAX_LEN; i++) pat_q[i] <= pattern_in[3*i +: 3];
                len_q     <= pattern_length;
                nb_q      <= num_balls_in;
                occ       <= '0;
                head      <= '0;
                idx       <= 3'd0;
                fresh_cnt <= 3'd0;
                error_out <= 1'b0;
`ifdef SISWAP_HAND_EN
                beat_par  <= 1'b0;
`endif
            end

            if (drop) begin
                occ <= '0;
            end

            if (beat_go) begin
                // Landing slot is consumed on every beat; the target is never head.
                occ[head] <= 1'b0;
                if (h != 3'd0) begin
                    if (hand_vld) begin
                        if (occ[tgt]) error_out <= 1'b1;
                        occ[tgt]         <= 1'b1;
                        qball[tgt]       <= hand_ball;
                        throw_valid_out  <= 1'b1;
                        throw_ball_out   <= hand_ball;
                        throw_height_out <= h;
`ifdef SISWAP_HAND_EN
                        throw_hand_out   <= beat_par;
`endif
                    end else begin
                        error_out <= 1'b1;
                    end
                end else if (slot_occ) begin
                    // A landing ball cannot be held through a 0 beat.
                    error_out <= 1'b1;
                end else begin
                    empty_beat_out <= 1'b1;
                end
                if (fresh_take) fresh_cnt <= fresh_cnt + 3'd1;
                head            <= head + 1'b1;
                idx             <= (idx == len_q - 3'd1) ? 3'd0 : idx + 3'd1;
                pattern_idx_out <= idx;
`ifdef SISWAP_HAND_EN
                beat_par        <= ~beat_par;
`endif
            end
        end
    end

endmodule
